// File: rtl/centroid_divider_cxy.sv
// Centroid divider: two parallel bit-serial restoring dividers turn the per-frame
// centroid accumulators into CX = H_TOTAL / SUM and CY = V_TOTAL / SUM at a fixed 19-cycle latency.
module centroid_divider_cxy #(
  parameter int Q_WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               IN_VALID,
  input  logic [17:0]        H_TOTAL,
  input  logic [17:0]        V_TOTAL,
  input  logic [12:0]        SUM,
  input  logic [12:0]        MIN_AREA,
  output logic [Q_WIDTH-1:0] CX,
  output logic [Q_WIDTH-1:0] CY,
  output logic [12:0]        AREA,
  output logic               FOUND,
  output logic               OUT_VALID,
  output logic               BUSY,
  output logic               DROPPED
);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t      state;
  logic [17:0] h_dvd, v_dvd;
  logic [17:0] h_quo, v_quo;
  logic [13:0] h_rem, v_rem;
  logic [12:0] sum_q, min_q;
  logic [4:0]  cnt;

  logic [13:0] divisor;
  logic [13:0] h_trial, v_trial;
  logic        found_w;

  function automatic logic [Q_WIDTH-1:0] sat_q(input logic [17:0] q);
    if ((q >> Q_WIDTH) != 18'd0) return '1;
    return q[Q_WIDTH-1:0];
  endfunction

  function automatic logic area_ok(input logic [12:0] s, input logic [12:0] m);
    return (s != 13'd0) && (s >= m);
  endfunction

  // The remainder always stays below SUM (< 2^13), so dropping its MSB loses nothing.
  // With SUM == 0 the remainder may wrap, but that result is discarded by FOUND.
  assign divisor = {1'b0, sum_q};
  assign h_trial = {h_rem[12:0], h_dvd[17]};
  assign v_trial = {v_rem[12:0], v_dvd[17]};
  assign found_w = area_ok(sum_q, min_q);
  assign BUSY    = (state != IDLE);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      h_dvd     <= '0;
      v_dvd     <= '0;
      h_quo     <= '0;
      v_quo     <= '0;
      h_rem     <= '0;
      v_rem     <= '0;
      sum_q     <= '0;
      min_q     <= '0;
      cnt       <= '0;
      CX        <= '0;
      CY        <= '0;
      AREA      <= '0;
      FOUND     <= 1'b0;
      OUT_VALID <= 1'b0;
      DROPPED   <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      DROPPED   <= IN_VALID && (state != IDLE);
      case (state)
        // Capture stage: latch operands and clear the divider state
        IDLE: begin
          if (IN_VALID) begin
            h_dvd <= H_TOTAL;
            v_dvd <= V_TOTAL;
            sum_q <= SUM;
            min_q <= MIN_AREA;
            h_rem <= '0;
            v_rem <= '0;
            h_quo <= '0;
            v_quo <= '0;
            cnt   <= '0;
            state <= DIV;
          end
        end
        // Iteration stage: one quotient bit per divider per cycle, MSB first
        DIV: begin
          if (h_trial >= divisor) begin
            h_rem <= h_trial - divisor;
            h_quo <= {h_quo[16:0], 1'b1};
          end else begin
            h_rem <= h_trial;
            h_quo <= {h_quo[16:0], 1'b0};
          end
          if (v_trial >= divisor) begin
            v_rem <= v_trial - divisor;
            v_quo <= {v_quo[16:0], 1'b1};
          end else begin
            v_rem <= v_trial;
            v_quo <= {v_quo[16:0], 1'b0};
          end
          h_dvd <= {h_dvd[16:0], 1'b0};
          v_dvd <= {v_dvd[16:0], 1'b0};
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd17) state <= DONE;
        end
        // Result stage: saturate, apply the area gate, strobe OUT_VALID
        DONE: begin
          CX        <= found_w ? sat_q(h_quo) : '0;
          CY        <= found_w ? sat_q(v_quo) : '0;
          AREA      <= sum_q;
          FOUND     <= found_w;
          OUT_VALID <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_divider_cxy.sv
// Scoreboard bench for centroid_divider_cxy: expected results are queued at issue
// and compared, including latency, whenever OUT_VALID fires.
module tb_centroid_divider_cxy;

  localparam int QW = 8;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          IN_VALID;
  logic [17:0]   H_TOTAL, V_TOTAL;
  logic [12:0]   SUM, MIN_AREA;
  logic [QW-1:0] CX, CY;
  logic [12:0]   AREA;
  logic          FOUND, OUT_VALID, BUSY, DROPPED;

  centroid_divider_cxy #(.Q_WIDTH(QW)) dut (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID),
    .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .SUM(SUM), .MIN_AREA(MIN_AREA),
    .CX(CX), .CY(CY), .AREA(AREA), .FOUND(FOUND),
    .OUT_VALID(OUT_VALID), .BUSY(BUSY), .DROPPED(DROPPED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int cx;
    int cy;
    int area;
    int found;
    int due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_drop = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  function automatic int ref_coord(input int t, input int s, input bit found);
    int q;
    if (!found) return 0;
    q = t / s;
    return (q > (1 << QW) - 1) ? (1 << QW) - 1 : q;
  endfunction

  // Drive one IN_VALID pulse from a falling edge; optionally queue its expected result
  task automatic send(input int h, input int v, input int s, input int m, input bit push);
    exp_t e;
    bit   f;
    H_TOTAL  = h[17:0];
    V_TOTAL  = v[17:0];
    SUM      = s[12:0];
    MIN_AREA = m[12:0];
    IN_VALID = 1'b1;
    if (push) begin
      f       = (s != 0) && (s >= m);
      e.cx    = ref_coord(h, s, f);
      e.cy    = ref_coord(v, s, f);
      e.area  = s;
      e.found = f;
      e.due   = cyc + 20;
      sb.push_back(e);
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge CLK);
    check({tag, "_drain"}, sb.size(), 0);
    @(negedge CLK);
    check({tag, "_idle"}, BUSY, 0);
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (RSTn) begin
      if (DROPPED) n_drop++;
      if (OUT_VALID) begin
        if (sb.size() == 0) check("spurious_out_valid", 1, 0);
        else begin
          e = sb.pop_front();
          check("cx",      CX,    e.cx);
          check("cy",      CY,    e.cy);
          check("area",    AREA,  e.area);
          check("found",   FOUND, e.found);
          check("latency", cyc,   e.due);
        end
      end
    end
  end

  initial begin
    int d0, h, v, s, m;
    RSTn = 1'b0; IN_VALID = 1'b0;
    H_TOTAL = '0; V_TOTAL = '0; SUM = '0; MIN_AREA = '0;
    repeat (3) @(negedge CLK);
    check("rst_cx",   CX, 0);
    check("rst_cy",   CY, 0);
    check("rst_area", AREA, 0);
    check("rst_ctrl", {FOUND, OUT_VALID, BUSY, DROPPED}, 0);
    RSTn = 1'b1;
    @(negedge CLK);

    send(3950, 2000, 100, 10, 1);
    check("busy_run", BUSY, 1);
    drain("normal");
    send(189600, 141600, 4800, 10, 1);     drain("exact");
    send(262143, 200, 1, 1, 1);            drain("sat");
    send(12345, 6789, 0, 0, 1);            drain("sum0");
    send(50, 60, 5, 6, 1);                 drain("minarea");
    send(262143, 262143, 8191, 8191, 1);   drain("maxdiv");
    check("hold_cx", CX, 32);

    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(1, 8191);
      h = $urandom_range(0, 262143);
      v = $urandom_range(0, 262143);
      m = $urandom_range(0, 600);
      send(h, v, s, m, 1);
      drain("rand");
    end

    // Overlap: drop at E5, accept exactly 20 cycles after the first
    d0 = n_drop;
    send(3950, 2000, 100, 10, 1);
    repeat (4) @(negedge CLK);
    send(1000, 1000, 1, 1, 0);
    repeat (14) @(negedge CLK);
    send(800, 400, 20, 5, 1);
    drain("overlap");
    check("drop_once", n_drop - d0, 1);

    // IN_VALID landing on the DONE edge is dropped
    d0 = n_drop;
    send(900, 300, 30, 1, 1);
    repeat (18) @(negedge CLK);
    send(5, 5, 1, 1, 0);
    drain("drop_done");
    check("drop_e19", n_drop - d0, 1);

    // Reset in the middle of a division
    send(3950, 2000, 100, 10, 1);
    repeat (9) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("midrst_cx",   CX, 0);
    check("midrst_cy",   CY, 0);
    check("midrst_area", AREA, 0);
    check("midrst_ctrl", {FOUND, OUT_VALID, BUSY, DROPPED}, 0);
    sb.delete();
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    repeat (25) @(negedge CLK);
    send(4000, 1500, 100, 10, 1);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
